// File: rtl/sr_latch_write_ctrl_if.sv
// Write-request / latch-drive bundle between the controller and its SR latch.
// master: controller side (drives s, r, busy, ack, err); slave: requester + latch.
interface sr_latch_write_ctrl_if;
  logic req;
  logic d;
  logic q_fb;
  logic q_bar_fb;
  logic s;
  logic r;
  logic busy;
  logic ack;
  logic err;

  modport master (
    input  req,
    input  d,
    input  q_fb,
    input  q_bar_fb,
    output s,
    output r,
    output busy,
    output ack,
    output err
  );

  modport slave (
    output req,
    output d,
    output q_fb,
    output q_bar_fb,
    input  s,
    input  r,
    input  busy,
    input  ack,
    input  err
  );
endinterface

// File: rtl/sr_latch_write_ctrl.sv
// Clocked writer for a cross-coupled NOR SR latch: pulse, settle, verify, retry.
// Ports: clk, reset (sync, active-high); wr_io carries req/d/q_fb/q_bar_fb in, s/r/busy/ack/err out.
module sr_latch_write_ctrl #(
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int MAX_RETRY     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  sr_latch_write_ctrl_if.master wr_io
);

  localparam int CMAX = (PULSE_CYCLES > SETTLE_CYCLES) ?
                        PULSE_CYCLES : SETTLE_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] S_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] R_LAST = RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    SETTLE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rty_q, rty_d;
  logic          dv_q, dv_d;
  logic          s_q, s_d;
  logic          r_q, r_d;
  logic          busy_q, busy_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          pass;

  // 00 and 11 readbacks never match, so invalid latch states fail.
  assign pass = (wr_io.q_fb == dv_q) &&
                (wr_io.q_bar_fb == ~dv_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rty_q   <= '0;
      dv_q    <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rty_q   <= rty_d;
      dv_q    <= dv_d;
      s_q     <= s_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // s_d/r_d are only ever set together as a complementary pair.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rty_d   = rty_q;
    dv_d    = dv_q;
    s_d     = 1'b0;
    r_d     = 1'b0;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (wr_io.req) begin
          dv_d    = wr_io.d;
          rty_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          s_d     = wr_io.d;
          r_d     = ~wr_io.d;
          state_d = PULSE;
        end
      end
      PULSE: begin
        if (cnt_q == P_LAST) begin
          cnt_d   = '0;
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          s_d   = dv_q;
          r_d   = ~dv_q;
        end
      end
      SETTLE: begin
        if (cnt_q != S_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (pass) begin
            ack_d   = 1'b1;
            err_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else if (rty_q == R_LAST) begin
            ack_d   = 1'b1;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            rty_d   = rty_q + 1'b1;
            s_d     = dv_q;
            r_d     = ~dv_q;
            state_d = PULSE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign wr_io.s    = s_q;
  assign wr_io.r    = r_q;
  assign wr_io.busy = busy_q;
  assign wr_io.ack  = ack_q;
  assign wr_io.err  = err_q;

endmodule

// File: tb/tb_sr_latch_write_ctrl.sv
// Directed bench for sr_latch_write_ctrl with a behavioural SR latch on s/r.
// Vector table for main flows, hand sequence for invalid feedback with MAX_RETRY=0.
module tb_sr_latch_write_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  logic [1:0] fb = 2'd0;
  logic q_m = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_latch_write_ctrl_if u_if ();
  sr_latch_write_ctrl_if u2_if ();

  sr_latch_write_ctrl #(
    .PULSE_CYCLES(2),
    .SETTLE_CYCLES(1),
    .MAX_RETRY(2)
  ) u_dut (
    .clk(clk),
    .reset(rst),
    .wr_io(u_if.master)
  );

  sr_latch_write_ctrl #(
    .PULSE_CYCLES(2),
    .SETTLE_CYCLES(1),
    .MAX_RETRY(0)
  ) u_dut2 (
    .clk(clk),
    .reset(rst2),
    .wr_io(u2_if.master)
  );

  always @(posedge u_if.s or posedge u_if.r)
    q_m = u_if.s ? 1'b1 : 1'b0;

  // fb: 0 = real latch, 1 = stuck at q=0, 2 = invalid 11
  assign u_if.q_fb     = (fb == 2'd0) ? q_m :
                         (fb == 2'd1) ? 1'b0 : 1'b1;
  assign u_if.q_bar_fb = (fb == 2'd0) ? ~q_m : 1'b1;

  assign u2_if.q_fb     = 1'b1;
  assign u2_if.q_bar_fb = 1'b1;

  always @(negedge clk) begin
    checks++;
    if ((u_if.s & u_if.r) | (u2_if.s & u2_if.r)) begin
      errors++;
      $display("FAIL overlap t=%0t s/r=%b%b s2/r2=%b%b",
               $time, u_if.s, u_if.r, u2_if.s, u2_if.r);
    end
  end

  typedef struct {
    logic       rst;
    logic       req;
    logic       d;
    logic [1:0] fb;
    logic [5:0] exp;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rs, input logic rq, input logic dd,
                     input logic [1:0] f, input logic es, input logic er,
                     input logic eb, input logic ea, input logic ee,
                     input logic eq);
    vec_t v;
    v.rst = rs; v.req = rq; v.d = dd; v.fb = f;
    v.exp = {es, er, eb, ea, ee, eq};
    vq.push_back(v);
  endtask

  initial begin
    logic [5:0] got;
    int scyc;
    int k;
    logic seen;

    u_if.req = 1'b0;
    u_if.d = 1'b0;
    u2_if.req = 1'b0;
    u2_if.d = 1'b0;

    //    rst req d fb    s r b a e q
    add(1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    // set write, d changes after accept
    add(0, 1, 1, 0,   1, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0,   1, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0,   0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0,   0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0,   0, 0, 0, 0, 0, 1);
    // reset write
    add(0, 1, 0, 0,   0, 1, 1, 0, 0, 0);
    add(0, 0, 1, 0,   0, 1, 1, 0, 0, 0);
    add(0, 0, 1, 0,   0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0,   0, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0,   0, 0, 0, 0, 0, 0);
    // req while busy ignored, held req chains into a new write
    add(0, 1, 1, 0,   1, 0, 1, 0, 0, 1);
    add(0, 1, 0, 0,   1, 0, 1, 0, 0, 1);
    add(0, 1, 0, 0,   0, 0, 1, 0, 0, 1);
    add(0, 1, 0, 0,   0, 0, 0, 1, 0, 1);
    add(0, 1, 0, 0,   0, 1, 1, 0, 0, 0);
    add(0, 1, 0, 0,   0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0,   0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0,   0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    // stuck feedback: three attempts, sticky err
    add(0, 1, 1, 1,   1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1,   1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1,   0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1,   1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1,   1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1,   0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1,   1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1,   1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1,   0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1,   0, 0, 0, 1, 1, 0);
    add(0, 0, 1, 1,   0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 1,   0, 0, 0, 0, 1, 0);
    add(0, 1, 1, 0,   1, 0, 1, 0, 0, 1);
    add(0, 0, 1, 0,   1, 0, 1, 0, 0, 1);
    add(0, 0, 1, 0,   0, 0, 1, 0, 0, 1);
    add(0, 0, 1, 0,   0, 0, 0, 1, 0, 1);
    add(0, 0, 1, 0,   0, 0, 0, 0, 0, 1);
    // reset mid-PULSE, then a fresh full-length write
    add(0, 1, 1, 0,   1, 0, 1, 0, 0, 1);
    add(1, 0, 1, 0,   0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0,   0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0,   0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0,   0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0,   0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0,   0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst;
      u_if.req = vq[i].req;
      u_if.d = vq[i].d;
      fb = vq[i].fb;
      @(posedge clk);
      #1;
      got = {u_if.s, u_if.r, u_if.busy, u_if.ack, u_if.err, u_if.q_fb};
      checks++;
      if (got !== vq[i].exp) begin
        errors++;
        $display("FAIL vec%0d {s,r,busy,ack,err,q} got %b want %b",
                 i, got, vq[i].exp);
      end
    end

    // invalid feedback (11), MAX_RETRY=0: single attempt then err
    @(posedge clk);
    #1;
    checks++;
    if ({u2_if.s, u2_if.r, u2_if.busy, u2_if.ack, u2_if.err} !== 5'b0) begin
      errors++;
      $display("FAIL inv_reset got %b want 00000",
               {u2_if.s, u2_if.r, u2_if.busy, u2_if.ack, u2_if.err});
    end
    rst2 = 1'b0;
    u2_if.req = 1'b1;
    u2_if.d = 1'b1;
    @(posedge clk);
    #1;
    u2_if.req = 1'b0;
    scyc = u2_if.s ? 1 : 0;
    k = 0;
    seen = 1'b0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (u2_if.s) scyc++;
      if (u2_if.ack) begin
        seen = 1'b1;
        k = i;
      end
    end
    checks++;
    if (!seen || k != 3) begin
      errors++;
      $display("FAIL inv_ack_edge got seen=%0d edge=%0d want edge 3",
               seen, k);
    end
    checks++;
    if (u2_if.err !== 1'b1 || u2_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL inv_err err/busy got %b%b want 10",
               u2_if.err, u2_if.busy);
    end
    checks++;
    if (scyc != 2) begin
      errors++;
      $display("FAIL inv_pulses s cycles got %0d want 2", scyc);
    end
    @(posedge clk);
    #1;
    checks++;
    if (u2_if.err !== 1'b1 || u2_if.ack !== 1'b0) begin
      errors++;
      $display("FAIL inv_sticky err/ack got %b%b want 10",
               u2_if.err, u2_if.ack);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
